delay_v_sched: RTL

- Round-robin scheduler that shares one fixed-latency vector datapath (a delay_v-style pipeline, DELAY cycles, LENGTH lanes of WIDTH bits) between NREQ requesters.
- Accepts operand vectors with valid/ready, registers the granted vector into the datapath and tracks valid + requester id alongside it.
- Returns each result tagged with the id of the requester that issued it.
- Provides enable/flush sequencing so software can drain the pipeline cleanly.

---
 rtl/delay_v_sched_pkg.sv | 36 +++
 rtl/delay_v_sched_tag_delay_line.sv | 36 +++
 rtl/delay_v_sched.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/delay_v_sched_pkg.sv
// rtl/delay_v_sched_pkg.sv - shared types and round-robin pick helper for delay_v_sched
package delay_v_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    localparam int MAX_REQ  = 32;
    localparam int MAX_IDXW = 5;

    // One-hot grant of the first set request at or after ptr, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input int unsigned        ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0]  grant;
        int unsigned         idx;
        logic [MAX_IDXW-1:0] sel;
        grant = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            sel = idx[MAX_IDXW-1:0];
            if (k < n && grant == '0 && req[sel]) begin
                grant[sel] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/delay_v_sched_tag_delay_line.sv
// rtl/delay_v_sched_tag_delay_line.sv - shift register of {valid, id} tags riding alongside the datapath
module tag_delay_line #(
    parameter int DEPTH = 4,
    parameter int IDW   = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_valid,
    input  logic [IDW-1:0] push_id,
    output logic           tail_valid,
    output logic [IDW-1:0] tail_id
);

    logic [DEPTH-1:0] vld;
    logic [IDW-1:0]   ids [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ids[k] <= '0;
            end
        end else begin
            vld[0] <= push_valid;
            ids[0] <= push_id;
            for (int k = 1; k < DEPTH; k++) begin
                vld[k] <= vld[k-1];
                ids[k] <= ids[k-1];
            end
        end
    end

    assign tail_valid = vld[DEPTH-1];
    assign tail_id    = ids[DEPTH-1];

endmodule

// File: rtl/delay_v_sched.sv
// rtl/delay_v_sched.sv - round-robin scheduler sharing one fixed-latency vector datapath
module delay_v_sched
    import delay_v_sched_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 16,
    parameter int LENGTH = 4,
    parameter int DELAY  = 3,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          flush_req,
    output logic                          flush_done,
    output logic                          busy,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [WIDTH-1:0]              req_data [NREQ][LENGTH],
    output logic [WIDTH-1:0]              dp_a [LENGTH],
    input  logic [WIDTH-1:0]              dp_c [LENGTH],
    output logic                          rsp_valid,
    output logic [IDW-1:0]                rsp_id,
    output logic [WIDTH-1:0]              rsp_data [LENGTH],
    output logic [$clog2(DELAY+2)-1:0]    inflight
);

    localparam int IFW = $clog2(DELAY+2);

    sched_state_t       state, state_nxt;
    logic               fd_nxt;
    logic [IDW-1:0]     ptr;
    logic [MAX_REQ-1:0] req_pad;
    logic [MAX_REQ-1:0] pick;
    logic [NREQ-1:0]    issue_vec;
    logic               issue;
    logic [IDW-1:0]     issue_id;
    logic               unused_pick_hi;

    always_comb begin
        req_pad            = '0;
        req_pad[NREQ-1:0]  = req_valid;
        pick               = rr_pick(req_pad, 32'(ptr), NREQ);
        req_ready          = (state == RUN) ? pick[NREQ-1:0] : '0;
    end

    assign unused_pick_hi = ^pick[MAX_REQ-1:NREQ];
    assign issue_vec      = req_valid & req_ready;
    assign issue          = |issue_vec;

    always_comb begin
        issue_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (issue_vec[i]) begin
                issue_id = IDW'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        fd_nxt    = 1'b0;
        case (state)
            IDLE: begin
                // A flush with nothing to drain is acknowledged immediately.
                if (flush_req) begin
                    fd_nxt = 1'b1;
                end else if (enable) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush_req || !enable) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0) begin
                    state_nxt = IDLE;
                    fd_nxt    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_done <= fd_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (issue_id == IDW'(NREQ-1)) ? '0 : issue_id + 1'b1;
        end
    end

    // Idle slots push zeros so the datapath never sees a stale operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < LENGTH; l++) begin
                dp_a[l] <= '0;
            end
        end else begin
            for (int l = 0; l < LENGTH; l++) begin
                dp_a[l] <= issue ? req_data[issue_id][l] : '0;
            end
        end
    end

    tag_delay_line #(
        .DEPTH (DELAY + 1),
        .IDW   (IDW)
    ) u_tags (
        .clk        (clk),
        .rst        (rst),
        .push_valid (issue),
        .push_id    (issue_id),
        .tail_valid (rsp_valid),
        .tail_id    (rsp_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue, rsp_valid})
                2'b10:   inflight <= inflight + IFW'(1);
                2'b01:   inflight <= inflight - IFW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign rsp_data = dp_c;
    assign busy     = (state != IDLE) || (inflight != '0);

endmodule
